// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges per-stage stall requests into the pipeline stall bus,
// sequences exception/watchdog flushes and supplies the redirect PC.
`default_nettype none

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1023,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        excp_req_i,
  input  logic [31:0] excp_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        wdog_trap_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned   CW         = $clog2(TIMEOUT);
  localparam logic [CW-1:0] RUN_LAST   = CW'(TIMEOUT - 1);
  localparam logic [3:0]    FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]    flush_cnt_q, flush_cnt_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic          trap_q, trap_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic [5:0]    req_stall;
  logic          stall_any;
  logic          wdog_expire;

  // Deepest requesting stage wins; everything upstream of it is held too.
  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem_i)     req_stall = 6'b011111;
    else if (stallreq_ex_i) req_stall = 6'b001111;
    else if (stallreq_id_i) req_stall = 6'b000111;
    else if (stallreq_if_i) req_stall = 6'b000011;
  end

  assign stall_o     = (rst_n && state_q == ST_RUN) ? req_stall : 6'b000000;
  assign stall_any   = |stall_o;
  assign wdog_expire = (state_q == ST_RUN) && stall_any && (run_cnt_q == RUN_LAST);

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    trap_d      = trap_q;
    stall_cnt_d = stall_cnt_q;

    if (stall_any && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;

    case (state_q)
      ST_RUN: begin
        if (excp_req_i) begin
          // An exception outranks a simultaneous watchdog expiry.
          state_d     = ST_FLUSH;
          flush_cnt_d = 4'd0;
          new_pc_d    = excp_pc_i;
          run_cnt_d   = '0;
        end else if (wdog_expire) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 4'd0;
          new_pc_d    = TRAP_VEC;
          trap_d      = 1'b1;
          run_cnt_d   = '0;
        end else if (stall_any) begin
          run_cnt_d   = run_cnt_q + CW'(1);
        end else begin
          run_cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      run_cnt_q   <= '0;
      flush_cnt_q <= 4'd0;
      new_pc_q    <= 32'd0;
      trap_q      <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      new_pc_q    <= new_pc_d;
      trap_q      <= trap_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_o     = (state_q == ST_FLUSH);
  assign new_pc_o    = new_pc_q;
  assign wdog_trap_o = trap_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized scoreboard bench for pipe_ctrl.
`default_nettype none

module tb_pipe_ctrl;

  localparam int unsigned FC   = 4;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] TRAP = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sr_if = 1'b0, sr_id = 1'b0, sr_ex = 1'b0, sr_mem = 1'b0;
  logic        excp = 1'b0;
  logic [31:0] excp_pc = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        trap;
  logic [31:0] scnt;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT(TO), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_if_i(sr_if), .stallreq_id_i(sr_id), .stallreq_ex_i(sr_ex),
    .stallreq_mem_i(sr_mem), .excp_req_i(excp), .excp_pc_i(excp_pc),
    .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc),
    .wdog_trap_o(trap), .stall_cnt_o(scnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model state
  bit          m_flush;
  int          m_left;
  int          m_run;
  bit          m_trap;
  logic [31:0] m_pc;
  longint      m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Holding stage d and all upstream stages: pc plus (d+1) pipeline regs.
  function automatic logic [5:0] model_stall(input logic [3:0] req);
    for (int d = 3; d >= 0; d--)
      if (req[d]) return 6'((1 << (d + 2)) - 1);
    return 6'd0;
  endfunction

  function automatic void model_reset();
    m_flush = 0; m_left = 0; m_run = 0; m_trap = 0; m_pc = 32'd0; m_cnt = 0;
  endfunction

  // One clock cycle: drive after the edge, predict outputs, advance the model.
  // req = {mem, ex, id, if}. mid drops reset partway through the cycle.
  task automatic cycle(input bit r, input logic [3:0] req, input bit ex,
                       input logic [31:0] pc, input bit mid = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; {sr_mem, sr_ex, sr_id, sr_if} = req; excp = ex; excp_pc = pc;
    if (mid) begin
      #1 rst_n = 1'b0;
      #1 chk("async_flush_drop", {31'd0, flush}, 32'd0);
    end
    if (!r || mid) begin
      model_reset();
      e = '{stall: 6'd0, flush: 1'b0, pc: 32'd0, trap: 1'b0, cnt: 32'd0};
      exp_q.push_back(e);
      return;
    end
    e.stall = m_flush ? 6'd0 : model_stall(req);
    e.flush = m_flush;
    e.pc    = m_pc;
    e.trap  = m_trap;
    e.cnt   = 32'(m_cnt);
    exp_q.push_back(e);
    if (e.stall != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (m_flush) begin
      m_left--;
      if (m_left == 0) m_flush = 0;
    end else if (ex) begin
      m_flush = 1; m_left = FC; m_pc = pc; m_run = 0;
    end else if (e.stall != 0) begin
      m_run++;
      if (m_run == TO) begin
        m_flush = 1; m_left = FC; m_pc = TRAP; m_trap = 1; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",     {26'd0, stall}, {26'd0, e.stall});
      chk("flush",     {31'd0, flush}, {31'd0, e.flush});
      chk("new_pc",    new_pc,         e.pc);
      chk("wdog_trap", {31'd0, trap},  {31'd0, e.trap});
      chk("stall_cnt", scnt,           e.cnt);
    end
  end

  initial begin
    model_reset();
    // Reset with every request and an exception asserted
    repeat (3) cycle(0, 4'b1111, 1, 32'hDEAD_BEEF);
    // Priority
    cycle(1, 4'b0010, 0, 0);
    cycle(1, 4'b1010, 0, 0);
    cycle(1, 4'b1011, 0, 0);
    cycle(1, 4'b0001, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    // Exception during ALU stall, with late exceptions ignored
    cycle(1, 4'b0100, 1, 32'hBFC0_0380);
    cycle(1, 4'b1111, 1, 32'h1234_5678);
    repeat (FC) cycle(1, 4'b0100, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    // Watchdog gap: 7 stalled, 1 idle, 7 stalled
    repeat (7) cycle(1, 4'b1000, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    repeat (7) cycle(1, 4'b1000, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    // Watchdog expiry from a fresh reset
    cycle(0, 4'b0000, 0, 0);
    repeat (TO + FC + 3) cycle(1, 4'b1000, 0, 0);
    repeat (2) cycle(1, 4'b0000, 0, 0);
    // Reset in the second flush cycle
    cycle(1, 4'b0010, 1, 32'h8000_0100);
    cycle(1, 4'b0000, 0, 0);
    cycle(1, 4'b0000, 0, 0, 1);
    repeat (3) cycle(1, 4'b0100, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit mid;
      bit ex;
      mid = ($urandom_range(0, 299) == 0);
      ex  = ($urandom_range(0, 24) == 0);
      cycle(1, 4'($urandom), ex, $urandom, mid);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
